// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 constants, types and the small sigma helpers.
// Used by the message-schedule expander and by the round engine.
// Pure declarations: no state, no clocking.
package sha256_msg_schedule_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_BLK_W  = 512;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA256_WINDOW = 16;
  localparam int SHA256_IDX_W  = 6;

  // Rotate/shift amounts for the two small sigma functions.
  localparam int SIG0_ROT_A = 7;
  localparam int SIG0_ROT_B = 18;
  localparam int SIG0_SHR   = 3;
  localparam int SIG1_ROT_A = 17;
  localparam int SIG1_ROT_B = 19;
  localparam int SIG1_SHR   = 10;

  typedef logic [SHA256_WORD_W-1:0] word_t;
  typedef logic [SHA256_IDX_W-1:0]  idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (SHA256_WORD_W - n));
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, SIG0_ROT_A) ^ rotr(x, SIG0_ROT_B) ^ (x >> SIG0_SHR);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, SIG1_ROT_A) ^ rotr(x, SIG1_ROT_B) ^ (x >> SIG1_SHR);
  endfunction

  // Word i of a block, most significant word first (word 0 = bits 511:480).
  function automatic word_t blk_word(input logic [SHA256_BLK_W-1:0] blk, input int unsigned i);
    return blk[SHA256_BLK_W-1-SHA256_WORD_W*i -: SHA256_WORD_W];
  endfunction

endpackage

// File: rtl/sha256_sched_sum.sv
// Next schedule word: sig1(r14) + r9 + sig0(r1) + r0, modulo 2^32.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module sha256_sched_sum
  import sha256_msg_schedule_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] r0_i,
  input  logic [SHA256_WORD_W-1:0] r1_i,
  input  logic [SHA256_WORD_W-1:0] r9_i,
  input  logic [SHA256_WORD_W-1:0] r14_i,
  output logic [SHA256_WORD_W-1:0] w_new_o
);

  word_t s0;
  word_t s1;

  // Sigma terms and the 4-input sum; the carry out of bit 31 is simply dropped.
  always_comb begin
    s0      = sig0(r1_i);
    s1      = sig1(r14_i);
    w_new_o = s1 + r9_i + s0 + r0_i;
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads a 512-bit block, streams W[0..ROUNDS-1].
// Latency: start accepted in cycle N -> W[0] valid in cycle N+1; one word per accept.
// Backpressure: w_valid & !w_ready holds word, index and window; start ignored while busy.
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SHA256_BLK_W-1:0]  blk_in,
  output logic                     busy,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [SHA256_WORD_W-1:0] w_out,
  output logic [SHA256_IDX_W-1:0]  w_idx,
  output logic                     done
);

  localparam idx_t LAST_IDX = idx_t'(ROUNDS - 1);

  sched_state_e state_q, state_d;
  idx_t         t_q, t_d;
  logic         done_q, done_d;
  word_t        win_q [SHA256_WINDOW];
  word_t        win_d [SHA256_WINDOW];
  word_t        w_new;

  // W[t+16] from the current window; only captured when the window shifts.
  sha256_sched_sum u_sum (
    .r0_i    (win_q[0]),
    .r1_i    (win_q[1]),
    .r9_i    (win_q[9]),
    .r14_i   (win_q[14]),
    .w_new_o (w_new)
  );

  // Next-state logic: load on start in IDLE, shift/advance on every accepted word in RUN.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    for (int i = 0; i < SHA256_WINDOW; i++) begin
      win_d[i] = win_q[i];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < SHA256_WINDOW; i++) begin
            win_d[i] = blk_word(blk_in, i);
          end
          t_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_ready) begin
          if (t_q == LAST_IDX) begin
            // Final word taken: the window is left as is, it is never emitted again.
            state_d = ST_IDLE;
            t_d     = '0;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + idx_t'(1);
            for (int i = 0; i < SHA256_WINDOW - 1; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[SHA256_WINDOW-1] = w_new;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and window registers; reset clears everything so no block resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < SHA256_WINDOW; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      for (int i = 0; i < SHA256_WINDOW; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // The head of the window is always the word on offer.
  always_comb begin
    busy    = (state_q == ST_RUN);
    w_valid = (state_q == ST_RUN);
    w_out   = win_q[0];
    w_idx   = t_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench: expected words queued at start, monitors compare on each accept.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, w_ready, busy, w_valid, done;
  logic [511:0] blk_in;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;

  logic         start16, w_ready16, busy16, w_valid16, done16;
  logic [511:0] blk16;
  logic [31:0]  w_out16;
  logic [5:0]   w_idx16;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_in(blk_in), .busy(busy),
    .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out), .w_idx(w_idx), .done(done)
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .blk_in(blk16), .busy(busy16),
    .w_valid(w_valid16), .w_ready(w_ready16), .w_out(w_out16), .w_idx(w_idx16), .done(done16)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] w;
  } exp_t;

  exp_t        q64[$];
  exp_t        q16[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] seen_w [64];
  logic [31:0] mw [64];
  int          done_cnt = 0, accepts = 0;
  int          done16_cnt = 0, acc16 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule recurrence over the whole array.
  task automatic build_model(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) mw[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(mw[t-15], 7) ^ ror(mw[t-15], 18) ^ (mw[t-15] >> 3);
      s1 = ror(mw[t-2], 17) ^ ror(mw[t-2], 19) ^ (mw[t-2] >> 10);
      mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
    end
  endtask

  task automatic push_block(input logic [511:0] b, input int rounds, input bit to16);
    exp_t e;
    build_model(b);
    for (int t = 0; t < rounds; t++) begin
      e.idx = 6'(t);
      e.w   = mw[t];
      if (to16) q16.push_back(e);
      else      q64.push_back(e);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start, then scramble blk_in and check the first word arrives next cycle.
  task automatic do_start(input logic [511:0] b);
    logic [31:0] w0;
    w0     = b[511:480];
    start  = 1'b1;
    blk_in = b;
    tick();
    start  = 1'b0;
    blk_in = rand_blk();
    check("latency_valid", {62'd0, w_valid, busy}, {62'd0, 2'b11});
    check("latency_w0", {32'd0, w_out}, {32'd0, w0});
  endtask

  // Consume until the queue empties; optional ignored start at idx 20 or break at stop_idx.
  task automatic drain(input bit rnd, input bit inject, input int stop_idx, input int budget);
    int n;
    n = 0;
    while (q64.size() != 0 && n < budget) begin
      if (stop_idx >= 0 && w_valid && int'(w_idx) == stop_idx) break;
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && w_valid && w_idx == 6'd20) begin
        start  = 1'b1;
        blk_in = rand_blk();
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (n >= budget) fail("drain_timeout");
  endtask

  // Monitor for the 64-round instance: scoreboard pops, stall hold, done pulse timing.
  bit          stall_p = 0, exp_done = 0;
  logic [31:0] stall_w;
  logic [5:0]  stall_i;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_p  = 0;
      exp_done = 0;
    end else begin
      check("done64", {63'd0, done}, {63'd0, exp_done});
      exp_done = 0;
      if (done) done_cnt++;
      if (stall_p)
        check("stall_hold", {25'd0, w_valid, w_idx, w_out}, {25'd0, 1'b1, stall_i, stall_w});
      stall_p = w_valid && !w_ready;
      stall_w = w_out;
      stall_i = w_idx;
      if (w_valid && w_ready) begin
        accepts++;
        seen_w[w_idx] = w_out;
        if (q64.size() == 0) begin
          fail("unexpected_word64");
        end else begin
          e = q64.pop_front();
          check("w_idx64", {58'd0, w_idx}, {58'd0, e.idx});
          check("w_out64", {32'd0, w_out}, {32'd0, e.w});
          if (e.idx == 6'd63) exp_done = 1;
        end
      end
    end
  end

  // Monitor for the 16-round instance.
  bit exp_done16 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_done16 = 0;
    end else begin
      check("done16", {63'd0, done16}, {63'd0, exp_done16});
      exp_done16 = 0;
      if (done16) done16_cnt++;
      if (w_valid16 && w_ready16) begin
        acc16++;
        if (q16.size() == 0) begin
          fail("unexpected_word16");
        end else begin
          e = q16.pop_front();
          check("w_idx16", {58'd0, w_idx16}, {58'd0, e.idx});
          check("w_out16", {32'd0, w_out16}, {32'd0, e.w});
          if (e.idx == 6'd15) exp_done16 = 1;
        end
      end
    end
  end

  initial begin
    logic [511:0] abc, b2, b3;
    int n;
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;

    rst = 1'b0; start = 1'b0; w_ready = 1'b0; blk_in = '0;
    start16 = 1'b0; w_ready16 = 1'b1; blk16 = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_outs", {25'd0, busy, w_valid, done, w_idx, w_out}, 64'd0);
    check("reset_outs16", {25'd0, busy16, w_valid16, done16, w_idx16, w_out16}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: "abc" with ready always high
    done_cnt = 0;
    push_block(abc, 64, 0);
    do_start(abc);
    drain(0, 0, -1, 200);
    check("valid_falls", {62'd0, w_valid, busy}, 64'd0);
    tick(); tick();
    check("abc_w0",  {32'd0, seen_w[0]},  {32'd0, 32'h61626380});
    check("abc_w15", {32'd0, seen_w[15]}, {32'd0, 32'h00000018});
    check("abc_w16", {32'd0, seen_w[16]}, {32'd0, 32'h61626380});
    check("abc_w17", {32'd0, seen_w[17]}, {32'd0, 32'h000F0000});
    check("abc_done_cnt", 64'(done_cnt), 64'd1);

    // 2: all-zero block
    accepts = 0;
    push_block('0, 64, 0);
    do_start('0);
    drain(0, 0, -1, 200);
    tick();
    check("zero_accepts", 64'(accepts), 64'd64);

    // 3: "abc" with random back-pressure
    push_block(abc, 64, 0);
    do_start(abc);
    drain(1, 0, -1, 2000);
    tick();

    // 4: ignored start at idx 20, then a start in the done cycle
    push_block(abc, 64, 0);
    do_start(abc);
    drain(0, 1, -1, 200);
    check("done_cycle", {63'd0, done}, {63'd0, 1'b1});
    b2 = rand_blk();
    push_block(b2, 64, 0);
    do_start(b2);
    drain(1, 0, -1, 2000);
    tick();

    // 5: asynchronous reset at idx 30, then a fresh block
    b3 = rand_blk();
    push_block(b3, 64, 0);
    do_start(b3);
    drain(1, 0, 30, 2000);
    check("reached_idx30", {58'd0, w_idx}, {58'd0, 6'd30});
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", {25'd0, busy, w_valid, done, w_idx, w_out}, 64'd0);
    q64.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    b3 = rand_blk();
    push_block(b3, 64, 0);
    do_start(b3);
    drain(1, 0, -1, 2000);
    tick(); tick();

    // 6: 16-round build emits exactly the block words
    done16_cnt = 0;
    acc16 = 0;
    b2 = rand_blk();
    push_block(b2, 16, 1);
    start16 = 1'b1;
    blk16   = b2;
    tick();
    start16 = 1'b0;
    blk16   = rand_blk();
    n = 0;
    while (q16.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail("drain16_timeout");
    tick(); tick();
    check("r16_accepts", 64'(acc16), 64'd16);
    check("r16_done_cnt", 64'(done16_cnt), 64'd1);
    check("r16_idle", {62'd0, busy16, w_valid16}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
